// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for alu_seq, plus the signed-overflow rule.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SRA = 4'b1101;

    // IDLE: nothing held | MBUSY: multiplier iterating | FULL: result awaiting consumer
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MBUSY = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                        input logic sign_r, input logic is_sub);
        if (is_sub)
            return (sign_a != sign_b) && (sign_r != sign_a);
        else
            return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the operand-fetch stage, alu_seq and writeback.
interface alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic [3:0]       ALUop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             Z;
    logic             V;
    logic             err;

    modport master (
        output in_valid, input_a, input_b, ALUop, out_ready,
        input  in_ready, out_valid, result, Z, V, err
    );

    modport slave (
        input  in_valid, input_a, input_b, ALUop, out_ready,
        output in_ready, out_valid, result, Z, V, err
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add multiplier: one partial product per cycle, low WIDTH bits kept.
// The final partial product is summed combinationally so the product is ready with done.
module alu_mul_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] step;
    logic             last;

    assign step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last = busy_q && (count_q == SHW'(WIDTH - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            count_d  = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
            if (last)
                busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = last;
    assign product = step;
endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered-output ALU. Define ALU_SEQ_MUL_EN to add the iterative
// multiplier (MUL op, MBUSY state); without it MUL is reported as an illegal op.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d;
    logic             v_q, v_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v, alu_err;
    logic             in_ready_c, accept, is_mul;

    assign a     = bus.input_a;
    assign b     = bus.input_b;
    assign shamt = b[SHW-1:0];

`ifdef ALU_SEQ_MUL_EN
    logic             mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] mul_product;

    assign is_mul     = (bus.ALUop == OP_MUL);
    assign mul_start  = accept && is_mul;
    assign in_ready_c = ((state_q == IDLE) || ((state_q == FULL) && bus.out_ready)) && !mul_busy;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul     = 1'b0;
    assign in_ready_c = (state_q == IDLE) || ((state_q == FULL) && bus.out_ready);
`endif

    assign accept = bus.in_valid && in_ready_c;

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (bus.ALUop)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOR: alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = a + b;
                alu_v   = signed_ovf(a[WIDTH-1], b[WIDTH-1], alu_res[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_v   = signed_ovf(a[WIDTH-1], b[WIDTH-1], alu_res[WIDTH-1], 1'b1);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: alu_res = a << shamt;
            OP_SRL: alu_res = a >> shamt;
            OP_SRA: alu_res = $signed(a) >>> shamt;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        z_d      = z_q;
        v_d      = v_q;
        err_d    = err_q;
        case (state_q)
`ifdef ALU_SEQ_MUL_EN
            MBUSY: begin
                if (mul_done) begin
                    state_d  = FULL;
                    result_d = mul_product;
                    z_d      = (mul_product == '0);
                    v_d      = 1'b0;
                    err_d    = 1'b0;
                end
            end
`endif
            default: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = MBUSY;
                    end else begin
                        state_d  = FULL;
                        result_d = alu_res;
                        z_d      = (alu_res == '0);
                        v_d      = alu_v;
                        err_d    = alu_err;
                    end
                end else if ((state_q == FULL) && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            z_q      <= z_d;
            v_q      <= v_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == FULL);
    assign bus.result    = result_q;
    assign bus.Z         = z_q;
    assign bus.V         = v_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=64); honours ALU_SEQ_MUL_EN for MUL expectations.
module tb_alu_seq;
    localparam int W = 64;
`ifdef ALU_SEQ_MUL_EN
    localparam int MUL_LAT = W + 1;
`else
    localparam int MUL_LAT = 1;
`endif

    typedef struct packed {
        logic [63:0] res;
        logic        z;
        logic        v;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   rand_rdy = 1'b0;
    exp_t exp_q[$];
    int   out_cyc[$];

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Reference behaviour from the op definitions, using widened arithmetic for overflow.
    function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic [64:0] wide;
        int sh;
        e = '0;
        sh = int'(b[5:0]);
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0011: e.res = a ^ b;
            4'b1100: e.res = ~(a | b);
            4'b0010: begin
                wide = {a[63], a} + {b[63], b};
                e.res = wide[63:0];
                e.v = wide[64] ^ wide[63];
            end
            4'b0110: begin
                wide = {a[63], a} - {b[63], b};
                e.res = wide[63:0];
                e.v = wide[64] ^ wide[63];
            end
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'b0100: e.res = a << sh;
            4'b0101: e.res = a >> sh;
            4'b1101: e.res = 64'($signed(a) >>> sh);
`ifdef ALU_SEQ_MUL_EN
            4'b1000: e.res = a * b;
`else
            4'b1000: e.err = 1'b1;
`endif
            default: e.err = 1'b1;
        endcase
        e.z = (e.res == 64'd0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", bus.result, e.res);
                check("flags_zve", {61'd0, bus.Z, bus.V, bus.err}, {61'd0, e.z, e.v, e.err});
            end
            out_cyc.push_back(cyc);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output int waits);
        bit done;
        bus.in_valid = 1'b1;
        bus.ALUop    = op;
        bus.input_a  = a;
        bus.input_b  = b;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 300) begin
                    check("accept_timeout", 64'(waits), 64'd0);
                    done = 1'b1;
                end else begin
                    @(posedge clk);
                    #1;
                    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        if (waits <= 300) exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        bus.in_valid  = 1'b0;
        rand_rdy      = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input string name, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b);
        int w;
        bus.out_ready = 1'b1;
        issue(op, a, b, w);
        check(name, {63'd0, bus.out_valid}, 64'd1);
        drain();
    endtask

    initial begin
        int w, lat, seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.ALUop     = 4'd0;
        bus.input_a   = '0;
        bus.input_b   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_flags", {61'd0, bus.Z, bus.V, bus.err}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run1("lat_add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        run1("lat_sub_zero", 4'b0110, 64'd5, 64'd5);
        run1("lat_sra", 4'b1101, 64'h8000_0000_0000_0000, 64'h43);
        run1("lat_srl", 4'b0101, 64'h8000_0000_0000_0000, 64'h43);
        run1("lat_slt", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run1("lat_illegal", 4'b1111, 64'h1234, 64'h5678);

        // Backpressure: result held, second op not captured while out_ready is low.
        bus.out_ready = 1'b0;
        issue(4'b0001, 64'hF0, 64'h0F, w);
        bus.in_valid = 1'b1;
        bus.ALUop    = 4'b1100;
        bus.input_a  = 64'd1;
        bus.input_b  = 64'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_result_hold", bus.result, 64'hFF);
            check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        issue(4'b1100, 64'd1, 64'd2, w);
        check("bp_same_cycle_accept", 64'(w), 64'd0);
        drain();

        // Streaming: 16 single-cycle ops, results on 16 consecutive cycles.
        out_cyc.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            logic [63:0] a, b;
            op = 4'(i % 8) ^ ((i % 8 == 0) ? 4'b1100 : 4'b0000);
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            issue(op, a, b, w);
            check("stream_no_stall", 64'(w), 64'd0);
        end
        drain();
        check("stream_count", 64'(out_cyc.size()), 64'd16);
        if (out_cyc.size() == 16)
            check("stream_consecutive", 64'(out_cyc[15] - out_cyc[0]), 64'd15);

        // MUL latency and value (or illegal without the multiplier).
        bus.out_ready = 1'b1;
        issue(4'b1000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, w);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("mul_latency", 64'(lat), 64'(MUL_LAT));
        drain();

        // Randomized mix with random output backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            issue(op, {$urandom, $urandom}, {$urandom, $urandom}, w);
        end
        drain();

        // Reset in the middle of a MUL: everything discarded, nothing emerges afterwards.
        bus.out_ready = 1'b0;
        issue(4'b1000, 64'd5, 64'd7, w);
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_mid_result", bus.result, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("post_reset_quiet", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 64-bit combinational datapath ALU.
- Adds WIDTH generalisation, registered outputs, valid/ready flow control, shift/XOR ops, an overflow flag, and an optional iterative multiplier.
- Sits between operand-fetch and writeback stages of the pipelined/multi-cycle datapath.

Parameters:
- WIDTH, 64: operand/result width in bits; must be a power of two, ≥8.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  block can accept an operation this cycle.
- input_a  in  WIDTH  operand A.
- input_b  in  WIDTH  operand B; low SHW bits are the shift amount.
- ALUop  in  4  operation select.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- Z  out  1  registered; result == 0.
- V  out  1  registered; signed overflow for ADD/SUB, else 0.
- err  out  1  registered; illegal/unsupported ALUop.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE.
  - result=0, Z=0, V=0, err=0, out_valid=0.
  - Multiplier registers cleared.
  - Any in-flight operation is discarded; no output appears after reset release.
- Transfers: input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
- ALUop encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR.
  - 0100 SLL, 0101 SRL, 1101 SRA.
  - 0110 SUB, 0111 SLT (signed, result 1 or 0), 1100 NOR.
  - 1000 MUL (low WIDTH bits of a*b).
  - All other codes are illegal: result=0, Z=1, err=1, latency 1.
- Arithmetic: modulo 2^WIDTH.
  - V for ADD: operand sign bits equal and result sign differs.
  - V for SUB: operand sign bits differ and result sign differs from a.
- State machine:
  - IDLE: no result held; in_ready=1.
    - Single-cycle op accepted → FULL; result is registered on that edge (latency 1).
    - MUL accepted → MBUSY; count=0.
  - MBUSY: in_ready=0. One shift-add step per cycle. After WIDTH steps (count==WIDTH-1) → FULL with the product registered. Latency is WIDTH+1 cycles from accept to out_valid.
  - FULL: out_valid=1; result, Z, V and err are held stable until the output transfer.
    - in_ready = out_ready, so back-to-back throughput is 1 op/cycle for single-cycle ops.
    - Output transfer with no input transfer → IDLE.
    - Simultaneous output transfer and single-cycle input → stays FULL with the new result.
    - Simultaneous output transfer and MUL input → MBUSY.
- Operands and op are captured at accept. Input changes afterwards have no effect.
- in_valid with in_ready=0: no capture; the upstream producer must hold its values.
- Shift amount ≥WIDTH is impossible (low SHW bits only). SRA replicates input_a[WIDTH-1].

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL (1000) supported via the iterative multiplier, as above.
- Undefined: no multiplier logic and no MBUSY state. 1000 is treated as illegal (result=0, Z=1, err=1, latency 1).

Decomposition:
- Package alu_pkg:
  - 4-bit ALUop localparams (OP_AND … OP_MUL).
  - State encoding (IDLE, MBUSY, FULL).
  - Function for the signed-overflow calculation.
- One sub-module, alu_mul_seq: radix-2 shift-add multiplier.
  - Interface: start, a, b, busy, done, product, parameterised on WIDTH.
  - Instantiated only under ALU_SEQ_MUL_EN.

Test Plan:
- Reset mid-MUL: accept MUL 5×7, assert rst at cycle 10 → out_valid=0 and result=0 immediately; no completion is ever seen after release.
- ADD overflow (WIDTH=64): a=0x7FFF_FFFF_FFFF_FFFF, b=1, op 0010 → next cycle result=0x8000_0000_0000_0000, V=1, Z=0; SUB a=5, b=5 → result=0, Z=1, V=0.
- Shifts/SLT: a=0x8000_0000_0000_0000, b=0x43 (shamt 3) → SRA=0xF000_0000_0000_0000, SRL=0x1000_0000_0000_0000; SLT a=-1, b=1 → result=1.
- Backpressure: hold out_ready=0 for 5 cycles after OR a=0xF0, b=0x0F → result=0xFF stable, in_ready=0, and a second in_valid is not captured; release → second op accepted the same cycle.
- Streaming: 16 consecutive single-cycle ops with out_ready=1 → 16 results in order on 16 consecutive cycles.
- MUL (macro on): a=0xFFFF_FFFF, b=0xFFFF_FFFF → out_valid exactly 65 cycles after accept, result=0xFFFF_FFFE_0000_0001. Macro off: same op → err=1, result=0, 1-cycle latency. Illegal op 1111 → err=1, Z=1 in both builds.
